// File: rtl/req_encoder4_2_if.sv
// Request/grant bundle between event sources, the round-robin encoder and its one-hot consumer.
// The encoder takes the master view; sources and the consumer take the slave view.
interface req_encoder4_2_if;
    logic [3:0] req;
    logic       ready_in;
    logic       valid_out;
    logic [1:0] sel_out;
    logic       en_out;
    logic [3:0] pending_out;
    logic [7:0] drop_cnt;

    modport master (
        input  req,
        input  ready_in,
        output valid_out,
        output sel_out,
        output en_out,
        output pending_out,
        output drop_cnt
    );

    modport slave (
        output req,
        output ready_in,
        input  valid_out,
        input  sel_out,
        input  en_out,
        input  pending_out,
        input  drop_cnt
    );
endinterface

// File: rtl/req_encoder4_2.sv
// Registered round-robin 4-to-2 request encoder: sticky pending flags, rotating-priority grant,
// 2-bit code held in a valid/ready output register that feeds a 2-to-4 decoder directly.
module req_encoder4_2 (
    input  logic               clk,
    input  logic               reset,
    req_encoder4_2_if.master   bus
);

    // Code c selects line 3-c, which is simply the bitwise inverse of the code.
    function automatic logic [1:0] code_to_line(input logic [1:0] code);
        return ~code;
    endfunction

    logic [3:0] pending_q, pending_d;
    logic       valid_q,   valid_d;
    logic [1:0] sel_q,     sel_d;
    logic [1:0] ptr_q,     ptr_d;
    logic [7:0] drop_q,    drop_d;

    logic       load;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic [3:0] grant;
    logic [3:0] dropped;
    logic [2:0] drop_inc;
    logic [8:0] drop_sum;

    assign load = ~valid_q | bus.ready_in;

    // Rotating search starting at ptr; selection only ever looks at registered pending flags.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && pending_q[code_to_line(cand)]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        grant = 4'b0000;
        if (load && found) begin
            grant = 4'b0001 << code_to_line(pick);
        end

        // A request landing on an already-pending, ungranted line is lost and counted.
        dropped   = bus.req & pending_q & ~grant;
        drop_inc  = 3'(dropped[0]) + 3'(dropped[1]) + 3'(dropped[2]) + 3'(dropped[3]);
        drop_sum  = {1'b0, drop_q} + 9'(drop_inc);
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        pending_d = (pending_q & ~grant) | bus.req;

        valid_d = valid_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            // An empty load retires the code but leaves sel and ptr where they were.
            valid_d = found;
            if (found) begin
                sel_d = pick;
                ptr_d = pick + 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 4'b0000;
            valid_q   <= 1'b0;
            sel_q     <= 2'b00;
            ptr_q     <= 2'b00;
            drop_q    <= 8'd0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.en_out      = valid_q;
    assign bus.sel_out     = sel_q;
    assign bus.pending_out = pending_q;
    assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_req_encoder4_2.sv
// Table-driven bench for req_encoder4_2 with a transfer scoreboard and a drop-saturation sequence.
module tb_req_encoder4_2;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic [1:0] es;
        logic [3:0] ep;
        logic [7:0] ed;
        logic       push;
        logic [1:0] pcode;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [1:0] exp_q[$];
    vec_t tbl[$];

    req_encoder4_2_if bus ();

    req_encoder4_2 dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                                input logic v, input logic [1:0] s, input logic [3:0] p,
                                input logic [7:0] d, input logic pu, input logic [1:0] pc);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y; t.ev = v; t.es = s; t.ep = p; t.ed = d;
        t.push = pu; t.pcode = pc;
        return t;
    endfunction

    // Scoreboard: every accepted code must match the next expected grant.
    always @(posedge clk) begin
        if (!rst && bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", {30'd0, bus.sel_out}, 32'hFFFF_FFFF);
            end else begin
                check("xfer_code", {30'd0, bus.sel_out}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input logic r, input logic [3:0] q, input logic y);
        @(negedge clk);
        rst          = r;
        bus.req      = q;
        bus.ready_in = y;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [1:0] s,
                              input logic [3:0] p, input logic [7:0] d);
        check({tag, "_valid"},   {31'd0, bus.valid_out},   {31'd0, v});
        check({tag, "_en"},      {31'd0, bus.en_out},      {31'd0, v});
        check({tag, "_sel"},     {30'd0, bus.sel_out},     {30'd0, s});
        check({tag, "_pending"}, {28'd0, bus.pending_out}, {28'd0, p});
        check({tag, "_drop"},    {24'd0, bus.drop_cnt},    {24'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.ready_in = 1'b0;

        // reset and single request
        tbl.push_back(mk(1, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(1, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0100, 1, 0, 2'b00, 4'b0100, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b01, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b01, 4'b0000, 0, 1, 2'b01));
        // round-robin order, then 1001
        tbl.push_back(mk(1, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 2'b00, 4'b1111, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b00, 4'b0111, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b01, 4'b0011, 0, 1, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b10, 4'b0001, 0, 1, 2'b01));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b11, 4'b0000, 0, 1, 2'b10));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b11, 4'b0000, 0, 1, 2'b11));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 2'b11, 4'b1001, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b00, 4'b0001, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b11, 4'b0000, 0, 1, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b11, 4'b0000, 0, 1, 2'b11));
        // stall and hold
        tbl.push_back(mk(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0010, 0, 0, 2'b00, 4'b0010, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 0, 1, 2'b10, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0010, 0, 1, 2'b10, 4'b0010, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1000, 0, 1, 2'b10, 4'b1010, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b00, 4'b0010, 0, 1, 2'b10));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b10, 4'b0000, 0, 1, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0, 1, 2'b10));
        // drop counting on a stalled line
        tbl.push_back(mk(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0100, 0, 0, 2'b00, 4'b0100, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0001, 0, 1, 2'b01, 4'b0001, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0001, 0, 1, 2'b01, 4'b0001, 1, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0001, 0, 1, 2'b01, 4'b0001, 2, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0001, 0, 1, 2'b01, 4'b0001, 3, 0, 2'b00));
        // several drops in one cycle, including the grant-cycle exemption
        tbl.push_back(mk(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 2'b00, 4'b1111, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 2'b00, 4'b1111, 3, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 2'b00, 4'b1111, 7, 0, 2'b00));
        // grant-cycle re-arm
        tbl.push_back(mk(1, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0100, 1, 0, 2'b00, 4'b0100, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0100, 1, 1, 2'b01, 4'b0100, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b01, 4'b0000, 0, 1, 2'b01));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b01, 4'b0000, 0, 1, 2'b01));
        // reset mid-operation
        tbl.push_back(mk(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1000, 0, 0, 2'b00, 4'b1000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0110, 0, 1, 2'b00, 4'b0110, 0, 0, 2'b00));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b1000, 1, 0, 2'b00, 4'b1000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 1, 2'b00, 4'b0000, 0, 0, 2'b00));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0, 1, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].rdy);
            if (tbl[i].push) exp_q.push_back(tbl[i].pcode);
            @(posedge clk);
            #1;
            check_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ep, tbl[i].ed);
        end

        // drop counter saturation: 300 pulses on a stalled, already-pending line
        drive(1, 4'b0000, 0);
        drive(0, 4'b0100, 0);
        drive(0, 4'b0001, 0);
        for (int n = 1; n <= 300; n++) begin
            drive(0, 4'b0001, 0);
            if (n == 254 || n == 255) begin
                @(posedge clk);
                #1;
                check_outs($sformatf("sat%0d", n), 1'b1, 2'b01, 4'b0001, 8'(n));
            end
        end
        @(posedge clk);
        #1;
        check_outs("sat300", 1'b1, 2'b01, 4'b0001, 8'd255);

        drive(1, 4'b0000, 0);
        @(posedge clk);
        #1;
        check_outs("sat_reset", 1'b0, 2'b00, 4'b0000, 8'd0);

        drive(0, 4'b0000, 0);
        @(posedge clk);
        #1;
        check("scoreboard_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
